// File: rtl/phase_sequencer_if.sv
// Sequencer control bus: run switch and instruction/flag inputs in, phase and strobes out.
interface phase_sequencer_if #(
  parameter int IC_WIDTH = 16
);
  logic                EXEC;
  logic [15:0]         COMMAND;
  logic [3:0]          SZCV;
  logic [4:0]          phase;
  logic                ir_we;
  logic                mem_we;
  logic                reg_we;
  logic                pc_inc;
  logic                pc_load;
  logic                running;
  logic                halted;
  logic [IC_WIDTH-1:0] icount;

  modport master (
    output EXEC, COMMAND, SZCV,
    input  phase, ir_we, mem_we, reg_we, pc_inc, pc_load, running, halted, icount
  );

  modport slave (
    input  EXEC, COMMAND, SZCV,
    output phase, ir_we, mem_we, reg_we, pc_inc, pc_load, running, halted, icount
  );
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: P1 fetch, P2 decode, P3 execute, P4 memory, P5 writeback.
// Define SINGLE_STEP_EN to stop after every instruction (one instruction per EXEC edge).
module phase_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int IC_WIDTH = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  phase_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_HALT} state_t;

  localparam logic [IC_WIDTH-1:0] IC_ONE = {{(IC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt, wait_nxt;
  logic                stop_pend, stop_nxt;
  logic                exec_q, exec_arm, exec_edge;
  logic                hlt_q, taken_q;
  logic [IC_WIDTH-1:0] icount;
  logic                in_run, last_p4;
  logic                cmd_st, cmd_hlt, cmd_regw, cmd_taken;
  logic                unused_bits;

  // exec_arm blocks a level already high out of reset from looking like an edge
  assign exec_edge = bus.EXEC & ~exec_q & exec_arm;
  assign in_run    = (state == S_P1) || (state == S_P2) || (state == S_P3) ||
                     (state == S_P4) || (state == S_P5);
  assign last_p4   = (state == S_P4) && (wait_cnt == 4'(MEM_WAIT));

  assign cmd_st   = bus.COMMAND[15:14] == 2'b01;
  assign cmd_hlt  = (bus.COMMAND[15:14] == 2'b11) && (bus.COMMAND[7:4] == 4'hf);
  assign cmd_regw = (bus.COMMAND[15:14] == 2'b00) ||
                    ((bus.COMMAND[15:14] == 2'b11) && (bus.COMMAND[7:4] <= 4'd12)) ||
                    (bus.COMMAND[15:11] == 5'b10000);
  assign unused_bits = ^{bus.COMMAND[3:0], bus.SZCV[1]};

  always_comb begin
    cmd_taken = 1'b0;
    if (bus.COMMAND[15:11] == 5'b10100) begin
      cmd_taken = 1'b1;
    end else if (bus.COMMAND[15:11] == 5'b10111) begin
      case (bus.COMMAND[10:8])
        3'b000:  cmd_taken = bus.SZCV[2];
        3'b001:  cmd_taken = bus.SZCV[3] ^ bus.SZCV[0];
        3'b010:  cmd_taken = bus.SZCV[2] | (bus.SZCV[3] ^ bus.SZCV[0]);
        3'b011:  cmd_taken = ~bus.SZCV[2];
        default: cmd_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    stop_nxt  = stop_pend;
    if (in_run && exec_edge) stop_nxt = 1'b1;
    case (state)
      S_IDLE: if (exec_edge) state_nxt = S_P1;
      S_P1:   state_nxt = S_P2;
      S_P2:   state_nxt = S_P3;
      S_P3:   state_nxt = S_P4;
      S_P4: begin
        if (last_p4) begin
          wait_nxt  = 4'd0;
          state_nxt = S_P5;
        end else begin
          wait_nxt  = wait_cnt + 4'd1;
        end
      end
      S_P5: begin
        if (hlt_q)         state_nxt = S_HALT;
        else if (stop_nxt) state_nxt = S_IDLE;
        else               state_nxt = S_P1;
      end
      default: state_nxt = S_HALT;
    endcase
`ifdef SINGLE_STEP_EN
    if (state_nxt == S_P1) stop_nxt = 1'b1;
`endif
    if (state_nxt == S_IDLE) stop_nxt = 1'b0;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      stop_pend <= 1'b0;
      exec_q    <= 1'b0;
      exec_arm  <= 1'b0;
      hlt_q     <= 1'b0;
      taken_q   <= 1'b0;
      icount    <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      stop_pend <= stop_nxt;
      exec_q    <= bus.EXEC;
      exec_arm  <= exec_arm | ~bus.EXEC;
      if (state == S_P2) hlt_q <= cmd_hlt;
      if (state == S_P3) taken_q <= cmd_taken;
      if ((state == S_P5) && !hlt_q) icount <= icount + IC_ONE;
    end
  end

  always_comb begin
    bus.phase = 5'b00000;
    case (state)
      S_P1:    bus.phase = 5'b00001;
      S_P2:    bus.phase = 5'b00010;
      S_P3:    bus.phase = 5'b00100;
      S_P4:    bus.phase = 5'b01000;
      S_P5:    bus.phase = 5'b10000;
      default: bus.phase = 5'b00000;
    endcase
  end

  assign bus.ir_we   = state == S_P1;
  assign bus.mem_we  = last_p4 & cmd_st;
  assign bus.reg_we  = (state == S_P5) & cmd_regw;
  assign bus.pc_load = (state == S_P5) & ~hlt_q & taken_q;
  assign bus.pc_inc  = (state == S_P5) & ~hlt_q & ~taken_q;
  assign bus.running = in_run;
  assign bus.halted  = state == S_HALT;
  assign bus.icount  = icount;
endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized self-checking bench for phase_sequencer against an instruction-level model.
module tb_phase_sequencer;
  localparam int MW  = 3;
  localparam int ICW = 4;
`ifdef SINGLE_STEP_EN
  localparam bit SSTEP = 1'b1;
`else
  localparam bit SSTEP = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET;
  phase_sequencer_if #(.IC_WIDTH(ICW)) bus ();
  phase_sequencer #(.MEM_WAIT(MW), .IC_WIDTH(ICW)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

  always #5 CLOCK = ~CLOCK;

  int npass = 0;
  int ntot  = 0;
  int ic_m  = 0;  // model retired-instruction count
  int st_m  = 0;  // model run state: 0 idle, 1 sitting in P1, 2 halted

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {bus.phase, bus.ir_we, bus.mem_we, bus.reg_we, bus.pc_inc, bus.pc_load,
            bus.running, bus.halted};
  endfunction

  function automatic logic [11:0] pack(input int ph, input bit ir, mw, rw, pi, pl, run, hl);
    logic [4:0] p;
    p = (ph == 0) ? 5'd0 : 5'(1 << (ph - 1));
    return {p, ir, mw, rw, pi, pl, run, hl};
  endfunction

  function automatic bit model_taken(input logic [15:0] c, input logic [3:0] f);
    bit s, z, v;
    s = f[3]; z = f[2]; v = f[0];
    if (c[15:11] == 5'b10100) return 1'b1;
    if (c[15:11] != 5'b10111) return 1'b0;
    case (c[10:8])
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      default: return 1'b0;
    endcase
  endfunction

  // Bring an idle sequencer into P1 with a fresh EXEC rising edge.
  task automatic start_instr();
    if (bus.EXEC) begin
      bus.EXEC = 1'b0;
      tick();
    end
    bus.EXEC = 1'b1;
    tick();
  endtask

  // Run one instruction from P1 through P5 and check every cycle plus the landing state.
  task automatic run(input logic [15:0] cmd, input logic [3:0] f, input bit stop_req);
    bit st, hl, rw, tk;
    int n, ph;
    logic [11:0] e;
    bus.COMMAND = cmd;
    bus.SZCV    = f;
    if (st_m == 0) start_instr();
    n  = 5 + MW;
    st = cmd[15:14] == 2'b01;
    hl = (cmd[15:14] == 2'b11) && (cmd[7:4] == 4'hf);
    rw = (cmd[15:14] == 2'b00) || ((cmd[15:14] == 2'b11) && (cmd[7:4] <= 4'd12)) ||
         (cmd[15:11] == 5'b10000);
    tk = model_taken(cmd, f);
    for (int k = 0; k < n; k++) begin
      ph = (k < 3) ? k + 1 : (k == n - 1) ? 5 : 4;
      e  = pack(ph, k == 0, st && (k == n - 2), rw && (ph == 5),
                (ph == 5) && !hl && !tk, (ph == 5) && !hl && tk, 1'b1, 1'b0);
      ntot++;
      if (obs() !== e) $display("FAIL instr %h cycle %0d: got %b want %b", cmd, k, obs(), e);
      else npass++;
      if (k == 1) bus.EXEC = 1'b0;
      if (k == 2 && stop_req) bus.EXEC = 1'b1;
      tick();
    end
    if (!hl) ic_m = (ic_m + 1) % (1 << ICW);
    st_m = hl ? 2 : (stop_req || SSTEP) ? 0 : 1;
    e = pack((st_m == 1) ? 1 : 0, st_m == 1, 1'b0, 1'b0, 1'b0, 1'b0, st_m == 1, st_m == 2);
    ntot++;
    if (obs() !== e) $display("FAIL after %h: got %b want %b", cmd, obs(), e);
    else npass++;
    ntot++;
    if (bus.icount !== ICW'(ic_m)) $display("FAIL icount after %h: got %0d want %0d", cmd, bus.icount, ic_m);
    else npass++;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    bus.EXEC = 1'b0; bus.COMMAND = 16'h0; bus.SZCV = 4'h0;
    tick(); tick();
    ntot++;
    if (obs() !== 12'd0 || bus.icount !== '0) $display("FAIL reset: got %b/%0d want 0/0", obs(), bus.icount);
    else npass++;
    RESET = 1'b1;
    tick(); tick();
    ic_m = 0; st_m = 0;
    ntot++;
    if (obs() !== 12'd0) $display("FAIL idle: got %b want 0", obs());
    else npass++;
  endtask

  task automatic test_add();
    run(16'hC000, 4'h0, 1'b0);
    run(16'hC000, 4'hf, 1'b1);
  endtask

  task automatic test_branch();
    run(16'hB800, 4'b0100, 1'b1);
    run(16'hB800, 4'b0000, 1'b1);
    run(16'hA000, 4'b0000, 1'b1);
    run(16'hB900, 4'b1000, 1'b1);
  endtask

  task automatic test_store();
    run(16'h4000, 4'h5, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] c;
    for (int i = 0; i < 24; i++) begin
      c = 16'($urandom);
      if ($urandom_range(0, 2) == 0) c[15:11] = 5'b10111;
      if (c[15:14] == 2'b11 && c[7:4] == 4'hf) c[4] = 1'b0;
      run(c, 4'($urandom), $urandom_range(0, 3) == 0);
    end
    if (st_m == 1) run(16'h0000, 4'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bus.COMMAND = 16'h4000;
    start_instr();
    tick(); tick(); tick();
    ntot++;
    if (bus.phase !== 5'b01000) $display("FAIL reach P4: got %b want 01000", bus.phase);
    else npass++;
    RESET = 1'b0;
    #1;
    ntot++;
    if (obs() !== 12'd0 || bus.icount !== '0) $display("FAIL mid reset: got %b/%0d want 0/0", obs(), bus.icount);
    else npass++;
    tick();
    ntot++;
    if (bus.mem_we !== 1'b0) $display("FAIL mem_we in reset: got %b want 0", bus.mem_we);
    else npass++;
    bus.EXEC = 1'b1;
    tick();
    RESET = 1'b1;
    ic_m = 0; st_m = 0;
    tick(); tick(); tick();
    ntot++;
    if (obs() !== 12'd0) $display("FAIL exec high from reset: got %b want 0", obs());
    else npass++;
    run(16'h0123, 4'h0, 1'b1);
  endtask

  task automatic test_halt();
    run(16'hC0F0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.EXEC = 1'b0; tick();
      bus.EXEC = 1'b1; tick(); tick();
      ntot++;
      if (obs() !== pack(0, 0, 0, 0, 0, 0, 0, 1) || bus.icount !== ICW'(ic_m))
        $display("FAIL halt hold %0d: got %b/%0d want halted/%0d", i, obs(), bus.icount, ic_m);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_store();
    test_random();
    test_reset_mid();
    test_halt();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, extra wait cycles spent in P4 (0..15).
REQ-002 SHALL have parameter IC_WIDTH, default 16, width of retired-instruction counter.
REQ-003 SHALL have port CLOCK input 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET input 1, asynchronous active-low reset.
REQ-005 SHALL have port EXEC input 1, run/stop request level from switch; rising edge detected internally.
REQ-006 SHALL have port COMMAND input 16, current instruction word.
REQ-007 SHALL have port SZCV input 4, flags S=[3] Z=[2] C=[1] V=[0].
REQ-008 SHALL have port phase output 5, one-hot P1..P5 in bits [0]..[4]; 0 when IDLE/HALT.
REQ-009 SHALL have ports ir_we, mem_we, reg_we, pc_inc, pc_load output 1 each, single-cycle strobes.
REQ-010 SHALL have ports running, halted output 1, and icount output IC_WIDTH.

Function
REQ-011 SHALL implement states IDLE, P1 fetch, P2 decode, P3 execute, P4 memory, P5 writeback, HALT.
REQ-012 SHALL detect EXEC rising edge by comparing EXEC with a one-cycle registered copy.
REQ-013 IDLE: EXEC edge -> P1 next cycle, running=1.
REQ-014 Sequence P1->P2->P3->P4->P5, one cycle each except P4 which lasts 1+MEM_WAIT cycles via wait counter.
REQ-015 P5 -> P1 if running and no stop pending; -> IDLE if stop pending; -> HALT if instruction is HLT.
REQ-016 EXEC edge while in P1..P5 SHALL set stop pending; cleared on entering IDLE; instruction in flight always completes.
REQ-017 ir_we SHALL be 1 only in P1.
REQ-018 HLT decode: COMMAND[15:14]=11 and COMMAND[7:4]=1111, sampled in P2.
REQ-019 mem_we SHALL be 1 only on last cycle of P4 when COMMAND[15:14]=01 (ST).
REQ-020 reg_we SHALL be 1 only in P5 when COMMAND[15:14]=00, or =11 with [7:4]<=1100, or [15:11]=10000.
REQ-021 Branch taken flag SHALL be registered at P3->P4 from SZCV: [15:11]=10100 always; [15:11]=10111 with [10:8] 000 Z, 001 S^V, 010 Z|(S^V), 011 !Z, others not taken.
REQ-022 In P5 exactly one of pc_load (branch taken) or pc_inc (otherwise) SHALL be 1; neither for HLT.
REQ-023 icount SHALL increment by 1 in P5 of every non-HLT instruction, wrapping from all-ones to 0.
REQ-024 HALT: halted=1, running=0, all strobes 0; EXEC ignored; exit only by RESET.
REQ-025 running SHALL be 1 in P1..P5, 0 in IDLE and HALT.

Reset
REQ-026 RESET low SHALL immediately force IDLE, phase=0, all strobes 0, running=0, halted=0, icount=0, stop pending=0, wait counter=0, EXEC edge register=EXEC-low value 0.
REQ-027 RESET asserted mid-instruction SHALL abandon it with no strobe emitted after assertion.
REQ-028 Leaving reset, an EXEC already high SHALL not count as an edge until it falls and rises again.

Configuration
REQ-029 Macro SINGLE_STEP_EN defined: stop pending SHALL be set automatically on every P1 entry, so each EXEC edge executes exactly one instruction then returns to IDLE.
REQ-030 Macro SINGLE_STEP_EN undefined: free-running per REQ-015/016.

Verification
REQ-031 Reset, EXEC 0->1, COMMAND=0xC000 (ADD), MEM_WAIT=0 -> ir_we cycle 1, reg_we+pc_inc cycle 5, icount=1, loops to P1.
REQ-032 COMMAND=0xB800 (BE), SZCV=0100 -> pc_load=1 in P5; SZCV=0000 -> pc_inc=1, pc_load=0.
REQ-033 COMMAND=0x4000 (ST), MEM_WAIT=3 -> P4 lasts 4 cycles, mem_we only on 4th, reg_we=0.
REQ-034 COMMAND=0xC0F0 (HLT) -> no strobes in P5, HALT, halted=1; further EXEC edges no effect.
REQ-035 Second EXEC edge during P3 -> instruction completes, IDLE after P5, icount +1; with SINGLE_STEP_EN, one instruction per edge.
REQ-036 RESET low during P4 -> IDLE same cycle, mem_we stays 0, icount=0.
